// File: rtl/multi_console.sv
`default_nettype none
// ============================================================================
// Module   : multi_console
// Brief    : NCH-channel console peripheral (per-channel RX/TX FIFOs) behind a
//            pipelined Wishbone slave. Optional macro: MULTI_CONSOLE_LOOPBACK_EN.
// Revision : 1.0
// ============================================================================
module multi_console #(
    parameter int NCH    = 4,
    parameter int LGNCH  = 2,
    parameter int DW     = 7,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [LGNCH+1:0]  i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_ack,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_data,
    output logic [NCH-1:0]    o_tx_stb,
    output logic [NCH*DW-1:0] o_tx_data,
    input  logic [NCH-1:0]    i_tx_busy,
    input  logic [NCH-1:0]    i_rx_stb,
    input  logic [NCH*DW-1:0] i_rx_data,
    output logic [NCH-1:0]    o_rx_int,
    output logic [NCH-1:0]    o_tx_int,
    output logic              o_int
);
    localparam int              c_DEPTH   = 1 << LGFLEN;
    localparam int              c_NSLOT   = 1 << LGNCH;
    localparam logic [10:0]     c_DEPTH11 = 11'(c_DEPTH);
    localparam logic [10:0]     c_HALF11  = 11'(c_DEPTH / 2);
    localparam logic [LGFLEN:0] c_PTR_ONE = (LGFLEN+1)'(1);

    logic             w_req;
    logic [LGNCH-1:0] w_ch;
    logic [1:0]       w_reg;
    logic             w_ch_ok;
    logic [10:0]      w_thr_in;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    assign w_req      = i_wb_cyc & i_wb_stb;
    assign w_ch       = i_wb_addr[LGNCH+1:2];
    assign w_reg      = i_wb_addr[1:0];
    assign w_ch_ok    = (32'(w_ch) < NCH);
    assign o_wb_stall = 1'b0;
    assign o_int      = |{o_rx_int, o_tx_int};
    assign w_unused   = ^{i_wb_data[30:13], i_wb_data[11]};

    // Threshold of 0 is meaningless; anything above depth could never fire.
    always_comb begin
        w_thr_in = i_wb_data[10:0];
        if (w_thr_in == 11'd0)
            w_thr_in = 11'd1;
        else if (w_thr_in > c_DEPTH11)
            w_thr_in = c_DEPTH11;
    end

    // Status vectors padded to the full address space so unused slots read 0.
    logic [c_NSLOT-1:0][10:0]   w_rx_fill, w_tx_fill, w_thr;
    logic [c_NSLOT-1:0][DW-1:0] w_rx_head;
    logic [c_NSLOT-1:0]         w_rx_empty, w_rx_err, w_tx_full, w_tx_err, w_lb, w_busy;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic                w_sel, w_setup_wr, w_flush, w_rx_rd, w_rx_clr, w_tx_wr, w_tx_clr;
            logic [LGFLEN:0]     r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
            logic [LGFLEN:0]     w_rx_cnt, w_tx_cnt;
            logic [DW-1:0]       r_rx_mem [c_DEPTH];
            logic [DW-1:0]       r_tx_mem [c_DEPTH];
            logic                r_rx_err, r_tx_err, r_rx_int, r_tx_int;
            logic [10:0]         r_thr;
            logic                w_rx_empty_c, w_rx_full_c, w_tx_empty_c, w_tx_full_c;
            logic                w_rx_pop, w_rx_push_req, w_rx_push, w_rx_ovf;
            logic                w_tx_push, w_tx_ovf, w_tx_drain;
            logic [DW-1:0]       w_rx_din, w_tx_head;

            assign w_sel      = w_req & w_ch_ok & (32'(w_ch) == c);
            assign w_setup_wr = w_sel & i_wb_we & (w_reg == 2'd0);
            assign w_flush    = w_setup_wr & i_wb_data[31];
            assign w_rx_rd    = w_sel & ~i_wb_we & (w_reg == 2'd2);
            assign w_rx_clr   = w_sel & i_wb_we & (w_reg == 2'd2) & i_wb_data[12];
            assign w_tx_wr    = w_sel & i_wb_we & (w_reg == 2'd3) & ~i_wb_data[12];
            assign w_tx_clr   = w_sel & i_wb_we & (w_reg == 2'd3) & i_wb_data[12];

            assign w_rx_cnt     = r_rx_wp - r_rx_rp;
            assign w_tx_cnt     = r_tx_wp - r_tx_rp;
            assign w_rx_empty_c = (r_rx_wp == r_rx_rp);
            assign w_tx_empty_c = (r_tx_wp == r_tx_rp);
            assign w_rx_full_c  = (r_rx_wp[LGFLEN] != r_rx_rp[LGFLEN]) &&
                                  (r_rx_wp[LGFLEN-1:0] == r_rx_rp[LGFLEN-1:0]);
            assign w_tx_full_c  = (r_tx_wp[LGFLEN] != r_tx_rp[LGFLEN]) &&
                                  (r_tx_wp[LGFLEN-1:0] == r_tx_rp[LGFLEN-1:0]);
            assign w_tx_head    = r_tx_mem[r_tx_rp[LGFLEN-1:0]];
            assign w_rx_pop     = w_rx_rd & ~w_rx_empty_c;

`ifdef MULTI_CONSOLE_LOOPBACK_EN
            logic r_lb;
            assign w_tx_drain    = ~w_tx_empty_c &
                                   (r_lb ? (~w_rx_full_c | w_rx_pop) : ~i_tx_busy[c]);
            assign w_rx_push_req = r_lb ? w_tx_drain : i_rx_stb[c];
            assign w_rx_din      = r_lb ? w_tx_head : i_rx_data[c*DW +: DW];
            assign o_tx_stb[c]   = ~w_tx_empty_c & ~r_lb;
            assign w_lb[c]       = r_lb;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n)
                    r_lb <= 1'b0;
                else if (w_setup_wr)
                    r_lb <= i_wb_data[30];
            end
`else
            assign w_tx_drain    = ~w_tx_empty_c & ~i_tx_busy[c];
            assign w_rx_push_req = i_rx_stb[c];
            assign w_rx_din      = i_rx_data[c*DW +: DW];
            assign o_tx_stb[c]   = ~w_tx_empty_c;
            assign w_lb[c]       = 1'b0;
`endif

            // A pop on the same edge frees the slot a full-FIFO push needs.
            assign w_rx_push = w_rx_push_req & (~w_rx_full_c | w_rx_pop);
            assign w_rx_ovf  = w_rx_push_req & w_rx_full_c & ~w_rx_pop;
            assign w_tx_push = w_tx_wr & ~w_tx_full_c;
            assign w_tx_ovf  = w_tx_wr & w_tx_full_c;

            always_ff @(posedge i_clk) begin
                if (w_rx_push)
                    r_rx_mem[r_rx_wp[LGFLEN-1:0]] <= w_rx_din;
                if (w_tx_push)
                    r_tx_mem[r_tx_wp[LGFLEN-1:0]] <= i_wb_data[DW-1:0];
            end

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_rx_wp  <= '0;
                    r_rx_rp  <= '0;
                    r_tx_wp  <= '0;
                    r_tx_rp  <= '0;
                    r_rx_err <= 1'b0;
                    r_tx_err <= 1'b0;
                    r_thr    <= 11'd1;
                    r_rx_int <= 1'b0;
                    r_tx_int <= 1'b1;
                end else begin
                    if (w_flush) begin
                        r_rx_wp  <= '0;
                        r_rx_rp  <= '0;
                        r_tx_wp  <= '0;
                        r_tx_rp  <= '0;
                        r_rx_err <= 1'b0;
                        r_tx_err <= 1'b0;
                    end else begin
                        if (w_rx_push)  r_rx_wp <= r_rx_wp + c_PTR_ONE;
                        if (w_rx_pop)   r_rx_rp <= r_rx_rp + c_PTR_ONE;
                        if (w_tx_push)  r_tx_wp <= r_tx_wp + c_PTR_ONE;
                        if (w_tx_drain) r_tx_rp <= r_tx_rp + c_PTR_ONE;
                        r_rx_err <= (r_rx_err & ~w_rx_clr) | w_rx_ovf;
                        r_tx_err <= (r_tx_err & ~w_tx_clr) | w_tx_ovf;
                    end
                    if (w_setup_wr)
                        r_thr <= w_thr_in;
                    r_rx_int <= (11'(w_rx_cnt) >= r_thr);
                    r_tx_int <= (11'(w_tx_cnt) <= c_HALF11);
                end
            end

            assign o_tx_data[c*DW +: DW] = w_tx_head;
            assign o_rx_int[c]   = r_rx_int;
            assign o_tx_int[c]   = r_tx_int;
            assign w_rx_fill[c]  = 11'(w_rx_cnt);
            assign w_tx_fill[c]  = 11'(w_tx_cnt);
            assign w_thr[c]      = r_thr;
            assign w_rx_head[c]  = r_rx_mem[r_rx_rp[LGFLEN-1:0]];
            assign w_rx_empty[c] = w_rx_empty_c;
            assign w_rx_err[c]   = r_rx_err;
            assign w_tx_full[c]  = w_tx_full_c;
            assign w_tx_err[c]   = r_tx_err;
            assign w_busy[c]     = i_tx_busy[c];
        end

        for (genvar p = NCH; p < c_NSLOT; p++) begin : g_pad
            assign w_rx_fill[p]  = '0;
            assign w_tx_fill[p]  = '0;
            assign w_thr[p]      = '0;
            assign w_rx_head[p]  = '0;
            assign w_rx_empty[p] = 1'b0;
            assign w_rx_err[p]   = 1'b0;
            assign w_tx_full[p]  = 1'b0;
            assign w_tx_err[p]   = 1'b0;
            assign w_lb[p]       = 1'b0;
            assign w_busy[p]     = 1'b0;
        end
    endgenerate

    always_comb begin
        w_rd_data = 32'd0;
        if (w_req && !i_wb_we) begin
            case (w_reg)
                2'd0:    w_rd_data = {1'b0, w_lb[w_ch], 19'd0, w_thr[w_ch]};
                2'd1:    w_rd_data = {5'd0, w_tx_fill[w_ch], 5'd0, w_rx_fill[w_ch]};
                2'd2:    w_rd_data = {19'd0, w_rx_err[w_ch], 3'd0, w_rx_empty[w_ch],
                                      w_rx_empty[w_ch] ? 8'd0 : 8'(w_rx_head[w_ch])};
                default: w_rd_data = {19'd0, w_tx_err[w_ch], 2'd0, w_tx_full[w_ch],
                                      w_busy[w_ch], 8'd0};
            endcase
        end
    end

    // Two-stage pipe: side effects and read capture at N+1, ack/data at N+2.
    logic        r_pend;
    logic [31:0] r_rd_data;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pend    <= 1'b0;
            r_rd_data <= 32'd0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'd0;
        end else begin
            r_pend    <= w_req;
            r_rd_data <= w_rd_data;
            o_wb_ack  <= r_pend & i_wb_cyc;
            o_wb_data <= r_rd_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multi_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_console
// Brief    : Directed self-checking bench for multi_console (4 ch, 8 slots, depth 4).
// Revision : 1.0
// ============================================================================
module tb_multi_console;
    localparam int NCH = 4, LGNCH = 3, DW = 7, LGFLEN = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [LGNCH+1:0]  addr = '0;
    logic [31:0]       wdat = '0;
    logic              ack, stall, intr;
    logic [31:0]       rdat;
    logic [NCH-1:0]    tx_stb, rx_int, tx_int;
    logic [NCH-1:0]    tx_busy = '0, rx_stb = '0;
    logic [NCH*DW-1:0] tx_data, rx_data = '0;

    int checks = 0;
    int errors = 0;

    multi_console #(.NCH(NCH), .LGNCH(LGNCH), .DW(DW), .LGFLEN(LGFLEN)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat),
        .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat),
        .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_rx_int(rx_int), .o_tx_int(tx_int), .o_int(intr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [LGNCH+1:0] ad(input int ch, input int r);
        return (LGNCH+2)'((ch << 2) | r);
    endfunction

    task automatic bus(input logic w, input logic [LGNCH+1:0] a, input logic [31:0] d,
                       output logic [31:0] q, output logic k);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        k = ack; q = rdat; cyc = 1'b0;
    endtask

    task automatic rx_push(input int ch, input logic [DW-1:0] d);
        @(negedge clk);
        rx_stb[ch] = 1'b1; rx_data[ch*DW +: DW] = d;
        @(negedge clk);
        rx_stb[ch] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] q; logic k;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, rdat, tx_stb} !== '0) begin
            errors++;
            $display("FAIL reset_bus: ack=%0b data=%h tx_stb=%b, expected 0/0/0", ack, rdat, tx_stb);
        end
        checks++;
        if ({rx_int, tx_int, intr} !== {4'h0, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL reset_int: rx_int=%b tx_int=%b int=%b, expected 0000/1111/1", rx_int, tx_int, intr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = ad(0, 1);
        @(negedge clk);
        stb = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_ack: ack=%0b, expected 0", ack);
        end
        rst_n = 1'b1; cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_late_ack: ack=%0b, expected 0", ack);
        end
        bus(1'b0, ad(0, 1), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0000}) begin
            errors++;
            $display("FAIL reset_fifo_ch0: ack=%0b data=%h, expected 1/00000000", k, q);
        end
        bus(1'b0, ad(0, 0), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0001}) begin
            errors++;
            $display("FAIL reset_setup_ch0: ack=%0b data=%h, expected 1/00000001", k, q);
        end
    endtask

    task automatic test_tx();
        logic [31:0] q; logic k;
        tx_busy = 4'b0100;
        bus(1'b1, ad(2, 3), 32'h41, q, k);
        bus(1'b1, ad(2, 3), 32'h42, q, k);
        bus(1'b0, ad(2, 1), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0002_0000}) begin
            errors++;
            $display("FAIL tx_fill: ack=%0b data=%h, expected 1/00020000", k, q);
        end
        bus(1'b0, ad(2, 3), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0100}) begin
            errors++;
            $display("FAIL tx_status_busy: ack=%0b data=%h, expected 1/00000100", k, q);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_stb[2], tx_data[14 +: 7]} !== {1'b1, 7'h41}) begin
                errors++;
                $display("FAIL tx_hold_busy: stb=%0b data=%h, expected 1/41", tx_stb[2], tx_data[14 +: 7]);
            end
        end
        tx_busy = 4'b0000;
        @(negedge clk);
        checks++;
        if ({tx_stb[2], tx_data[14 +: 7]} !== {1'b1, 7'h42}) begin
            errors++;
            $display("FAIL tx_second: stb=%0b data=%h, expected 1/42", tx_stb[2], tx_data[14 +: 7]);
        end
        @(negedge clk);
        checks++;
        if (tx_stb !== 4'b0000) begin
            errors++;
            $display("FAIL tx_drained: tx_stb=%b, expected 0000", tx_stb);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] q; logic k;
        for (int i = 0; i < 5; i++)
            rx_push(1, 7'(8'h10 + i));
        bus(1'b0, ad(1, 1), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0004}) begin
            errors++;
            $display("FAIL rx_ovf_fill: ack=%0b data=%h, expected 1/00000004", k, q);
        end
        checks++;
        if (rx_int !== 4'b0010) begin
            errors++;
            $display("FAIL rx_ovf_int: rx_int=%b, expected 0010", rx_int);
        end
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, ad(1, 2), 32'd0, q, k);
            checks++;
            if ({k, q} !== {1'b1, 32'h0000_1010 + 32'(i)}) begin
                errors++;
                $display("FAIL rx_ovf_pop%0d: ack=%0b data=%h, expected 1/%h", i, k, q, 32'h1010 + 32'(i));
            end
        end
        bus(1'b0, ad(1, 2), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_1100}) begin
            errors++;
            $display("FAIL rx_ovf_empty: ack=%0b data=%h, expected 1/00001100", k, q);
        end
        bus(1'b1, ad(1, 2), 32'h1000, q, k);
        bus(1'b0, ad(1, 2), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0100}) begin
            errors++;
            $display("FAIL rx_err_clear: ack=%0b data=%h, expected 1/00000100", k, q);
        end
    endtask

    task automatic test_threshold();
        logic [31:0] q; logic k;
        bus(1'b1, ad(0, 0), 32'd3, q, k);
        bus(1'b0, ad(0, 0), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0003}) begin
            errors++;
            $display("FAIL thr_readback: ack=%0b data=%h, expected 1/00000003", k, q);
        end
        rx_push(0, 7'h01);
        rx_push(0, 7'h02);
        @(negedge clk);
        checks++;
        if (rx_int[0] !== 1'b0) begin
            errors++;
            $display("FAIL thr_below: rx_int0=%0b, expected 0", rx_int[0]);
        end
        rx_stb[0] = 1'b1; rx_data[0 +: 7] = 7'h03;
        @(negedge clk);
        rx_stb[0] = 1'b0;
        checks++;
        if (rx_int[0] !== 1'b0) begin
            errors++;
            $display("FAIL thr_latency: rx_int0=%0b, expected 0", rx_int[0]);
        end
        @(negedge clk);
        checks++;
        if ({rx_int[0], intr} !== 2'b11) begin
            errors++;
            $display("FAIL thr_reached: rx_int0=%0b int=%0b, expected 1/1", rx_int[0], intr);
        end
        bus(1'b1, ad(0, 0), 32'd0, q, k);
        bus(1'b0, ad(0, 0), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0001}) begin
            errors++;
            $display("FAIL thr_zero: ack=%0b data=%h, expected 1/00000001", k, q);
        end
        bus(1'b1, ad(0, 0), 32'd2000, q, k);
        bus(1'b0, ad(0, 0), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0004}) begin
            errors++;
            $display("FAIL thr_saturate: ack=%0b data=%h, expected 1/00000004", k, q);
        end
        bus(1'b1, ad(0, 0), 32'h8000_0001, q, k);
        bus(1'b0, ad(0, 1), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0000}) begin
            errors++;
            $display("FAIL flush_fill: ack=%0b data=%h, expected 1/00000000", k, q);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] q; logic k;
        for (int i = 0; i < 4; i++)
            rx_push(3, 7'(8'h31 + i));
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = ad(3, 2);
        rx_stb[3] = 1'b1; rx_data[21 +: 7] = 7'h35;
        @(negedge clk);
        stb = 1'b0; rx_stb[3] = 1'b0;
        @(negedge clk);
        cyc = 1'b0;
        checks++;
        if ({ack, rdat} !== {1'b1, 32'h0000_0031}) begin
            errors++;
            $display("FAIL sim_pop_push: ack=%0b data=%h, expected 1/00000031", ack, rdat);
        end
        bus(1'b0, ad(3, 1), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0004}) begin
            errors++;
            $display("FAIL sim_fill: ack=%0b data=%h, expected 1/00000004", k, q);
        end
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, ad(3, 2), 32'd0, q, k);
            checks++;
            if ({k, q} !== {1'b1, 32'h0000_0032 + 32'(i)}) begin
                errors++;
                $display("FAIL sim_pop%0d: ack=%0b data=%h, expected 1/%h", i, k, q, 32'h32 + 32'(i));
            end
        end
        tx_busy[3] = 1'b1;
        for (int i = 0; i < 5; i++)
            bus(1'b1, ad(3, 3), 32'h60 + 32'(i), q, k);
        bus(1'b0, ad(3, 3), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_1300}) begin
            errors++;
            $display("FAIL tx_full_err: ack=%0b data=%h, expected 1/00001300", k, q);
        end
        checks++;
        if (tx_int[3] !== 1'b0) begin
            errors++;
            $display("FAIL tx_int_full: tx_int3=%0b, expected 0", tx_int[3]);
        end
        bus(1'b1, ad(3, 3), 32'h1000, q, k);
        bus(1'b0, ad(3, 3), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0300}) begin
            errors++;
            $display("FAIL tx_err_clear: ack=%0b data=%h, expected 1/00000300", k, q);
        end
        bus(1'b0, ad(3, 1), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0004_0000}) begin
            errors++;
            $display("FAIL tx_clear_nopush: ack=%0b data=%h, expected 1/00040000", k, q);
        end
        tx_busy[3] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({tx_stb, tx_int} !== {4'h0, 4'hF}) begin
            errors++;
            $display("FAIL tx_drain_all: tx_stb=%b tx_int=%b, expected 0000/1111", tx_stb, tx_int);
        end
    endtask

    task automatic test_back_to_back();
        logic              bw [4];
        logic [LGNCH+1:0]  ba [4];
        logic [31:0]       bd [4];
        logic [31:0]       be [4];
        logic [31:0]       q;
        logic              k;
        bw = '{1'b1, 1'b0, 1'b1, 1'b0};
        ba = '{ad(2, 0), ad(2, 0), ad(6, 3), ad(5, 0)};
        bd = '{32'd2, 32'd0, 32'h55, 32'd0};
        be = '{32'd0, 32'd2, 32'd0, 32'd0};
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                checks++;
                if ({ack, rdat, tx_stb} !== {1'b1, be[n-2], 4'h0}) begin
                    errors++;
                    $display("FAIL b2b_req%0d: ack=%0b data=%h tx_stb=%b, expected 1/%h/0000",
                             n - 2, ack, rdat, tx_stb, be[n-2]);
                end
            end
            if (n < 4) begin
                cyc = 1'b1; stb = 1'b1; we = bw[n]; addr = ba[n]; wdat = bd[n];
            end else begin
                stb = 1'b0; we = 1'b0;
            end
        end
        cyc = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra_ack: ack=%0b, expected 0", ack);
        end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = ad(1, 0); wdat = 32'd2;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_ack: ack=%0b, expected 0", ack);
        end
        bus(1'b0, ad(1, 0), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, 32'h0000_0002}) begin
            errors++;
            $display("FAIL abort_commit: ack=%0b data=%h, expected 1/00000002", k, q);
        end
    endtask

    task automatic test_loopback_bit();
        logic [31:0] q; logic k;
        logic [31:0] exp;
`ifdef MULTI_CONSOLE_LOOPBACK_EN
        exp = 32'h4000_0001;
`else
        exp = 32'h0000_0001;
`endif
        bus(1'b1, ad(1, 0), 32'h4000_0001, q, k);
        bus(1'b0, ad(1, 0), 32'd0, q, k);
        checks++;
        if ({k, q} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL setup_bit30: ack=%0b data=%h, expected 1/%h", k, q, exp);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_overflow();
        test_threshold();
        test_simultaneous();
        test_back_to_back();
        test_loopback_bit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multi_console.md
Name: multi_console

Overview:
- Parametrised, multi-channel successor to the single-channel console peripheral.
- Provides NCH independent console channels, each with a DW-bit RX FIFO and TX FIFO of depth 2^LGFLEN.
- Each channel has a programmable RX interrupt threshold, sticky overflow flags and per-channel interrupts.
- Sits as one pipelined Wishbone slave between the bus interconnect and NCH byte-stream console links (hexbus/UART side).

Parameters:
- NCH, 4: number of channels (1..16).
- LGNCH, 2: log2 channel-select width, ≥ ceil(log2(NCH)), minimum 1.
- DW, 7: console data width (5..8).
- LGFLEN, 4: log2 FIFO depth per direction (2..10).

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  LGNCH+2  {channel, reg[1:0]}
- i_wb_data  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  always 0
- o_wb_data  out  32  read data
- o_tx_stb  out  NCH  per-channel TX valid
- o_tx_data  out  NCH*DW  per-channel TX data; channel c occupies [c*DW +: DW]
- i_tx_busy  in  NCH  per-channel sink busy
- i_rx_stb  in  NCH  per-channel RX strobe
- i_rx_data  in  NCH*DW  per-channel RX data
- o_rx_int  out  NCH  RX fill ≥ threshold
- o_tx_int  out  NCH  TX fill ≤ half depth
- o_int  out  1  OR of all o_rx_int and o_tx_int bits

Behaviour:

Clock and reset:
- One clock, i_clk. Reset is asynchronous and active-low (i_reset_n); polarity and synchronicity are fixed.
- While i_reset_n is low:
  - all FIFOs empty; all sticky errors 0; all thresholds = 1; loopback bits 0.
  - o_wb_ack=0, o_tx_stb=0, o_wb_data=0.
  - o_rx_int=0, o_tx_int=all 1, o_int=1.
- Reset mid-transaction drops any pending ack; no ack is issued for a request accepted before reset.

Bus protocol:
- Never stalls.
- Request at cycle N (stb high): side effects (push/pop/config) commit at edge N+1; o_wb_ack and o_wb_data are valid at cycle N+2.
- If i_wb_cyc is low at N+1, the ack is suppressed.
- Back-to-back requests are fully pipelined: one ack per stb, in order.
- Addressed channel c ≥ NCH: reads return 0, writes are ignored; the request is still acked.

Register map (per channel; reg field of i_wb_addr):
- 0 SETUP
  - Write: bits[10:0] set the RX threshold (value 0 is stored as 1; values > depth saturate to depth); bit31=1 flushes both FIFOs and clears both errors.
  - Read: {bit30 loopback, bits[10:0] threshold}.
- 1 FIFO
  - Read: {5'b0, tx_fill[10:0], 5'b0, rx_fill[10:0]}; fill ranges 0..2^LGFLEN.
- 2 RXREG
  - Read pops the head: {19'b0, rx_err bit12, 3'b0, empty bit8, head zero-extended from DW to 8}.
  - Data is the head as of edge N+1.
  - Read while empty: bit8=1, data=0, no pointer change.
  - Write with bit12=1 clears rx_err.
- 3 TXREG
  - Write pushes i_wb_data[DW-1:0].
  - Write while full: data dropped, tx_err set (sticky).
  - Write with bit12=1: clears tx_err, no push.
  - Read: {19'b0, tx_err bit12, 2'b0, full bit9, busy bit8, 8'b0}; no side effects.

RX path:
- i_rx_stb[c] pushes i_rx_data[c] into RX FIFO c.
- Push while full: data dropped, rx_err set. Exception: if a pop of the same channel commits on the same edge, the push succeeds and the fill count is unchanged.
- Simultaneous push and pop when empty: the count goes 0→1 and the pop reports empty.

TX path:
- First-word fall-through: o_tx_stb[c] = TX FIFO c not empty; o_tx_data = head.
- The head advances on an edge where o_tx_stb && !i_tx_busy.
- Holds stable while busy.
- Push and drain on the same edge are both honoured.

Interrupts and pointers:
- Interrupts are registered, one cycle after the fill change.
- Pointers are LGFLEN+1 bits, wrapping modulo 2^(LGFLEN+1).
- full = MSBs differ and the low bits are equal.

Optional Feature:
- Macro: MULTI_CONSOLE_LOOPBACK_EN.
- Defined:
  - SETUP write bit30 sets per-channel loopback.
  - While loopback is set, the TX head drains into that channel's RX FIFO every cycle the RX FIFO is not full (a pop committing on the same edge counts as not full); no push is attempted while the RX FIFO is full, so rx_err is not set.
  - o_tx_stb[c] is forced to 0 and i_rx_stb[c] is ignored.
- Undefined: bit30 is ignored and reads as 0; no loopback logic is instantiated.

Test Plan:
- Reset: hold i_reset_n low mid-read → no ack; after release, FIFO reg of ch0 reads 0x00000000, o_tx_int=all 1, o_int=1.
- TX: write 0x41,0x42 to ch2 TXREG, i_tx_busy[2]=1 for 5 cycles → o_tx_data ch2 stays 0x41; release busy → 0x41 then 0x42 each accepted once, then o_tx_stb[2]=0.
- RX overflow (LGFLEN=2): 5 strobes on ch1 with 0x10..0x14 → rx_fill=4, rx_err=1; four RXREG reads return 0x10..0x13; fifth read returns bit8=1.
- Threshold: SETUP ch0 threshold=3; push 2 → o_rx_int[0]=0; third push → o_rx_int[0]=1 next cycle, o_int=1.
- Simultaneous events: ch3 RX full, RXREG read committing on the same edge as i_rx_stb → no rx_err, fill stays 2^LGFLEN; TX full write → tx_err=1, then write bit12 → tx_err=0.
- Pipelining/abort: 4 back-to-back stb (mixed channels) → 4 acks at N+2..N+5 with correct data; drop cyc after one stb → that ack suppressed.
